multicycle_ctrl: RTL and testbench

Multi-cycle control unit that sequences the existing datapath (PC, instruction ROM with IR, RegFile, ALU, DataRAM) through FETCH/DECODE/EXEC/MEM/WB phases, replacing the single-cycle decoder. It generates every write strobe, the mux selects and the ALU opcode from the IR fields. It supports free-run and single-step modes, and halts at a programmable address or on an illegal opcode.

---
 rtl/multicycle_ctrl_if.sv | 40 ++++
 rtl/multicycle_ctrl.sv | 172 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
// multicycle_ctrl_if : control/status bundle between the controller and datapath
// Rev 1.0
// ============================================================================
interface multicycle_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             run;
  logic             step;
  logic [31:0]      pc;
  logic [6:0]       op;
  logic [2:0]       funct3;
  logic             funct7_5;
  logic             ir_we;
  logic             pc_we;
  logic             rf_we;
  logic             mem_we;
  logic             alusrc_imm;
  logic             wd_sel_mem;
  logic [1:0]       imm_sel;
  logic [4:0]       aluop;
  logic [2:0]       state;
  logic             halted;
  logic             illegal;
  logic [CNT_W-1:0] instr_count;

  modport master (
    output run, step, pc, op, funct3, funct7_5,
    input  ir_we, pc_we, rf_we, mem_we, alusrc_imm, wd_sel_mem, imm_sel, aluop,
           state, halted, illegal, instr_count
  );

  modport slave (
    input  run, step, pc, op, funct3, funct7_5,
    output ir_we, pc_we, rf_we, mem_we, alusrc_imm, wd_sel_mem, imm_sel, aluop,
           state, halted, illegal, instr_count
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// multicycle_ctrl : FETCH/DECODE/EXEC/MEM/WB sequencer for the shared datapath
// Rev 1.0
// ============================================================================
module multicycle_ctrl #(
  parameter logic [31:0] HALT_ADDR = 32'h0040000c,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  multicycle_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    C_NONE  = 2'd0,
    C_LOAD  = 2'd1,
    C_STORE = 2'd2,
    C_ALU   = 2'd3
  } class_e;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;

  state_e           state_q, state_d;
  class_e           cls_q, cls_d;
  logic [4:0]       aluop_q, aluop_d;
  logic             alusrc_q, alusrc_d;
  logic [1:0]       imm_sel_q, imm_sel_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q;
  logic             retire;

  class_e     dec_cls;
  logic [4:0] dec_aluop, f3_aluop;
  logic       dec_alusrc, f3_ok;
  logic [1:0] dec_imm;

  // Instruction decode; only sampled while in DECODE
  always_comb begin
    dec_cls    = C_NONE;
    dec_aluop  = 5'b00000;
    dec_alusrc = 1'b0;
    dec_imm    = 2'd0;
    f3_ok      = 1'b1;
    f3_aluop   = 5'b00000;
    case (bus.funct3)
      3'b000:  f3_aluop = 5'b00000;
      3'b111:  f3_aluop = 5'b00001;
      3'b110:  f3_aluop = 5'b00010;
      3'b001:  f3_aluop = 5'b00100;
      3'b101:  f3_aluop = bus.funct7_5 ? 5'b00110 : 5'b00101;
      default: f3_ok    = 1'b0;
    endcase
    case (bus.op)
      OP_LOAD: begin
        dec_cls    = C_LOAD;
        dec_alusrc = 1'b1;
      end
      OP_STORE: begin
        dec_cls    = C_STORE;
        dec_alusrc = 1'b1;
        dec_imm    = 2'd1;
      end
      OP_LUI: begin
        dec_cls    = C_ALU;
        dec_aluop  = 5'b10011;
        dec_alusrc = 1'b1;
        dec_imm    = 2'd2;
      end
      OP_REG: begin
        if (f3_ok) begin
          dec_cls   = C_ALU;
          dec_aluop = (bus.funct3 == 3'b000 && bus.funct7_5) ? 5'b00011 : f3_aluop;
        end
      end
      OP_IMM: begin
        // bit 30 is immediate data for addi, so only the shifts look at it
        if (f3_ok) begin
          dec_cls    = C_ALU;
          dec_aluop  = f3_aluop;
          dec_alusrc = 1'b1;
        end
      end
      default: dec_cls = C_NONE;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    aluop_d   = aluop_q;
    alusrc_d  = alusrc_q;
    imm_sel_d = imm_sel_q;
    illegal_d = illegal_q;
    retire    = 1'b0;
    case (state_q)
      S_IDLE:   if (bus.run || bus.step) state_d = S_FETCH;
      S_FETCH:  state_d = (bus.pc == HALT_ADDR) ? S_HALT : S_DECODE;
      S_DECODE: begin
        cls_d     = dec_cls;
        aluop_d   = dec_aluop;
        alusrc_d  = dec_alusrc;
        imm_sel_d = dec_imm;
        if (dec_cls == C_NONE) begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC:   state_d = (cls_q == C_ALU) ? S_WB : S_MEM;
      S_MEM:    if (cls_q == C_STORE) retire = 1'b1; else state_d = S_WB;
      S_WB:     retire = 1'b1;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
    // run is only consulted at retire, so mid-instruction toggles are deferred
    if (retire) state_d = bus.run ? S_FETCH : S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cls_q     <= C_NONE;
      aluop_q   <= 5'b00000;
      alusrc_q  <= 1'b0;
      imm_sel_q <= 2'd0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      aluop_q   <= aluop_d;
      alusrc_q  <= alusrc_d;
      imm_sel_q <= imm_sel_d;
      illegal_q <= illegal_d;
      if (retire && (cnt_q != {CNT_W{1'b1}})) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  logic w_active;
  assign w_active = (state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB);

  assign bus.ir_we       = !rst && (state_q == S_FETCH) && (bus.pc != HALT_ADDR);
  assign bus.pc_we       = !rst && retire;
  assign bus.rf_we       = !rst && (state_q == S_WB);
  assign bus.mem_we      = !rst && (state_q == S_MEM) && (cls_q == C_STORE);
  assign bus.aluop       = w_active ? aluop_q   : 5'b00000;
  assign bus.alusrc_imm  = w_active ? alusrc_q  : 1'b0;
  assign bus.imm_sel     = w_active ? imm_sel_q : 2'd0;
  assign bus.wd_sel_mem  = w_active && (cls_q == C_LOAD);
  assign bus.state       = state_q;
  assign bus.halted      = (state_q == S_HALT);
  assign bus.illegal     = illegal_q;
  assign bus.instr_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// tb_multicycle_ctrl : randomized bench against a phase-list reference model
// Rev 1.0
// ============================================================================
module tb_multicycle_ctrl;

  localparam logic [31:0] HALT = 32'h0040000c;
  localparam int K_ALU = 0, K_LW = 1, K_SW = 2;

  typedef struct packed {
    logic       legal;
    logic [1:0] kind;
    logic [4:0] aluop;
    logic       src;
    logic [1:0] imm;
  } dec_t;

  logic clk = 1'b0;
  logic rst, run, step;
  always #5 clk = ~clk;

  multicycle_ctrl_if #(.CNT_W(16)) bus ();
  multicycle_ctrl_if #(.CNT_W(4))  bus4 ();

  // reference model state
  logic [31:0] rom [0:31];
  logic [31:0] m_base = 32'd0;
  logic [31:0] m_pc = 32'd0;
  logic [31:0] m_ir = 32'd0;
  int          m_seq [5];
  int          m_len = 0, m_pos = 0, m_cur = 0, m_cnt = 0;
  logic        m_ill = 1'b0;
  dec_t        m_dec = '0;

  int n_cmp = 0, n_bad = 0;

  assign bus.run  = run;   assign bus4.run  = run;
  assign bus.step = step;  assign bus4.step = step;
  assign bus.pc   = m_pc;  assign bus4.pc   = m_pc;
  assign bus.op   = m_ir[6:0];    assign bus4.op   = m_ir[6:0];
  assign bus.funct3 = m_ir[14:12]; assign bus4.funct3 = m_ir[14:12];
  assign bus.funct7_5 = m_ir[30];  assign bus4.funct7_5 = m_ir[30];

  multicycle_ctrl #(.HALT_ADDR(HALT), .CNT_W(16)) dut  (.clk(clk), .rst(rst), .bus(bus));
  multicycle_ctrl #(.HALT_ADDR(HALT), .CNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4));

  function automatic dec_t ref_decode(input logic [31:0] ir);
    dec_t d;
    d = '0;
    case (ir[6:0])
      7'h03: begin d.legal = 1; d.kind = 2'(K_LW); d.src = 1; end
      7'h23: begin d.legal = 1; d.kind = 2'(K_SW); d.src = 1; d.imm = 2'd1; end
      7'h37: begin d.legal = 1; d.kind = 2'(K_ALU); d.src = 1; d.imm = 2'd2; d.aluop = 5'd19; end
      7'h33, 7'h13: begin
        d.legal = 1;
        d.kind  = 2'(K_ALU);
        d.src   = (ir[6:0] == 7'h13);
        case (ir[14:12])
          3'd0: d.aluop = (ir[6:0] == 7'h33 && ir[30]) ? 5'd3 : 5'd0;
          3'd7: d.aluop = 5'd1;
          3'd6: d.aluop = 5'd2;
          3'd1: d.aluop = 5'd4;
          3'd5: d.aluop = ir[30] ? 5'd6 : 5'd5;
          default: d.legal = 0;
        endcase
      end
      default: d.legal = 0;
    endcase
    return d;
  endfunction

  // Each instruction is a fixed list of phases; the model just walks it
  task automatic m_fetch();
    m_cur = 1;
    m_pos = 0;
    if (m_pc == HALT) begin
      m_seq = '{1, 6, 0, 0, 0}; m_len = 2;
    end else begin
      m_ir  = rom[5'((m_pc - m_base) >> 2)];
      m_dec = ref_decode(m_ir);
      if (!m_dec.legal)                 begin m_seq = '{1, 2, 6, 0, 0}; m_len = 3; end
      else if (m_dec.kind == 2'(K_LW))  begin m_seq = '{1, 2, 3, 4, 5}; m_len = 5; end
      else if (m_dec.kind == 2'(K_SW))  begin m_seq = '{1, 2, 3, 4, 0}; m_len = 4; end
      else                              begin m_seq = '{1, 2, 3, 5, 0}; m_len = 4; end
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_cur = 0; m_cnt = 0; m_ill = 1'b0; m_pc = m_base; m_len = 0; m_pos = 0;
    end else begin
      case (m_cur)
        0: if (run || step) m_fetch();
        6: ;
        default: begin
          if (m_pos + 1 < m_len) begin
            m_pos = m_pos + 1;
            m_cur = m_seq[m_pos];
            if (m_cur == 6 && m_len == 3) m_ill = 1'b1;
          end else begin
            m_cnt = m_cnt + 1;
            m_pc  = m_pc + 32'd4;
            if (run) m_fetch(); else m_cur = 0;
          end
        end
      endcase
    end
  end

  function automatic logic [37:0] exp_vec();
    logic act;
    logic [15:0] c16;
    logic [3:0]  c4;
    act = (m_cur >= 3 && m_cur <= 5);
    c16 = (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt);
    c4  = (m_cnt > 15) ? 4'hF : 4'(m_cnt);
    return {3'(m_cur),
            !rst && m_cur == 1 && m_pc != HALT,
            !rst && (m_cur == 4 || m_cur == 5) && m_pos == m_len - 1,
            !rst && m_cur == 5,
            !rst && m_cur == 4 && m_dec.kind == 2'(K_SW),
            act && m_dec.src,
            act && m_dec.kind == 2'(K_LW),
            act ? m_dec.imm : 2'd0,
            act ? m_dec.aluop : 5'd0,
            m_cur == 6, m_ill, c16, c4};
  endfunction

  function automatic logic [37:0] obs_vec();
    return {bus.state, bus.ir_we, bus.pc_we, bus.rf_we, bus.mem_we, bus.alusrc_imm,
            bus.wd_sel_mem, bus.imm_sel, bus.aluop, bus.halted, bus.illegal,
            bus.instr_count, bus4.instr_count};
  endfunction

  function automatic logic [31:0] rand_instr(input bit allow_bad);
    logic [31:0] ir;
    int          k;
    int          f3s [5] = '{0, 7, 6, 1, 5};
    ir = $urandom();
    k  = $urandom_range(0, allow_bad ? 5 : 4);
    case (k)
      0: ir[6:0] = 7'h37;
      1: ir[6:0] = 7'h03;
      2: ir[6:0] = 7'h23;
      3: begin ir[6:0] = 7'h33; ir[14:12] = 3'(f3s[$urandom_range(0, 4)]); end
      4: begin ir[6:0] = 7'h13; ir[14:12] = 3'(f3s[$urandom_range(0, 4)]); end
      default: ;
    endcase
    return ir;
  endfunction

  task automatic do_reset(input logic [31:0] base);
    m_base = base;
    rst = 1'b1; run = 1'b0; step = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.ir_we !== 1'b0 || bus.pc_we !== 1'b0 || bus.rf_we !== 1'b0 || bus.mem_we !== 1'b0) begin
      n_bad++; $display("FAIL reset_strobes: got %b%b%b%b want 0000", bus.ir_we, bus.pc_we, bus.rf_we, bus.mem_we);
    end
    do_reset(32'h0);
    @(negedge clk);
    n_cmp++;
    if (bus.state !== 3'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", bus.state); end
    n_cmp++;
    if (bus.instr_count !== 16'd0 || bus.illegal !== 1'b0) begin
      n_bad++; $display("FAIL reset_status: got count %0d illegal %b want 0 0", bus.instr_count, bus.illegal);
    end
    n_cmp++;
    if (obs_vec() !== exp_vec()) begin n_bad++; $display("FAIL reset_vec: got %h want %h", obs_vec(), exp_vec()); end
  endtask

  task automatic test_program();
    int n = 0;
    do_reset(32'h00400000);
    rom[0] = 32'h123450B7; rom[1] = 32'h00002103; rom[2] = 32'h00202223;
    run = 1'b1;
    while (n < 40 && bus.halted !== 1'b1) begin
      @(negedge clk);
      n++;
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin n_bad++; $display("FAIL program_cycle%0d: got %h want %h", n, obs_vec(), exp_vec()); end
    end
    n_cmp++;
    if (n - 1 !== 14) begin n_bad++; $display("FAIL program_latency: got %0d cycles want 14", n - 1); end
    n_cmp++;
    if (bus.instr_count !== 16'd3 || bus.halted !== 1'b1) begin
      n_bad++; $display("FAIL program_end: got count %0d halted %b want 3 1", bus.instr_count, bus.halted);
    end
  endtask

  task automatic test_rtype_sweep();
    logic [3:0]  f [7] = '{4'h0, 4'h8, 4'h7, 4'h6, 4'h1, 4'h5, 4'hD};
    logic [4:0]  want [7] = '{5'd0, 5'd3, 5'd1, 5'd2, 5'd4, 5'd5, 5'd6};
    logic [4:0]  seen [7];
    int          nwb = 0, n = 0;
    do_reset(HALT - 32'd28);
    for (int i = 0; i < 7; i++) rom[i] = {1'b0, f[i][3], 15'd0, f[i][2:0], 5'd1, 7'h33};
    run = 1'b1;
    while (n < 60 && m_cur != 6) begin
      @(negedge clk);
      n++;
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin n_bad++; $display("FAIL rtype_cycle%0d: got %h want %h", n, obs_vec(), exp_vec()); end
      if (bus.rf_we === 1'b1) begin
        if (nwb < 7) seen[nwb] = bus.aluop;
        nwb++;
      end
    end
    n_cmp++;
    if (nwb !== 7) begin n_bad++; $display("FAIL rtype_rfwe_count: got %0d want 7", nwb); end
    for (int i = 0; i < 7; i++) begin
      n_cmp++;
      if (seen[i] !== want[i]) begin n_bad++; $display("FAIL rtype_aluop%0d: got %b want %b", i, seen[i], want[i]); end
    end
  endtask

  task automatic test_single_step();
    bit done = 0;
    do_reset(32'h3000);
    rom[0] = rand_instr(0);
    step = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin n_bad++; $display("FAIL step_cycle%0d: got %h want %h", i, obs_vec(), exp_vec()); end
      if (m_cur == 0) done = 1;
      step = (m_cur == 2 || m_cur == 3);
    end
    step = 1'b0;
    n_cmp++;
    if (bus.instr_count !== 16'd1 || bus.state !== 3'd0) begin
      n_bad++; $display("FAIL step_result: got count %0d state %0d want 1 0", bus.instr_count, bus.state);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] bad [2] = '{32'h00000063, 32'h00002033};
    for (int t = 0; t < 2; t++) begin
      int nstb = 0;
      do_reset(32'h1000);
      rom[0] = bad[t];
      run = 1'b1;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        n_cmp++;
        if (obs_vec() !== exp_vec()) begin n_bad++; $display("FAIL illegal%0d_cycle%0d: got %h want %h", t, i, obs_vec(), exp_vec()); end
        nstb += int'(bus.rf_we) + int'(bus.mem_we) + int'(bus.pc_we);
      end
      n_cmp++;
      if (bus.illegal !== 1'b1 || bus.halted !== 1'b1 || nstb !== 0) begin
        n_bad++; $display("FAIL illegal%0d_end: got illegal %b halted %b strobes %0d want 1 1 0", t, bus.illegal, bus.halted, nstb);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    do_reset(32'h2000);
    rom[0] = 32'h00002103;
    run = 1'b1;
    while (n < 12 && m_cur != 5) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (bus.state !== 3'd5) begin n_bad++; $display("FAIL rstmid_wb: got state %0d want 5", bus.state); end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.rf_we !== 1'b0 || bus.pc_we !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_strobes: got rf_we %b pc_we %b want 0 0", bus.rf_we, bus.pc_we);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.state !== 3'd0 || bus.instr_count !== 16'd0) begin
      n_bad++; $display("FAIL rstmid_after: got state %0d count %0d want 0 0", bus.state, bus.instr_count);
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      int n = 0;
      do_reset(HALT - 32'd24);
      for (int i = 0; i < 6; i++) rom[i] = rand_instr(1);
      run = 1'($urandom_range(0, 1));
      while (n < 300 && m_cur != 6) begin
        @(negedge clk);
        n++;
        n_cmp++;
        if (obs_vec() !== exp_vec()) begin n_bad++; $display("FAIL random%0d_cycle%0d: got %h want %h", r, n, obs_vec(), exp_vec()); end
        if ($urandom_range(0, 7) == 0) run = ~run;
        step = ($urandom_range(0, 2) == 0);
      end
      step = 1'b0;
      if (n >= 300) begin n_cmp++; n_bad++; $display("FAIL random%0d_timeout: got %0d cycles want <300", r, n); end
    end
  endtask

  task automatic test_saturate();
    int n = 0;
    do_reset(HALT - 32'd80);
    for (int i = 0; i < 20; i++) rom[i] = rand_instr(0);
    run = 1'b1;
    while (n < 200 && m_cur != 6) begin
      @(negedge clk);
      n++;
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin n_bad++; $display("FAIL sat_cycle%0d: got %h want %h", n, obs_vec(), exp_vec()); end
    end
    @(negedge clk);
    n_cmp++;
    if (bus4.instr_count !== 4'hF) begin n_bad++; $display("FAIL sat_cnt4: got %h want f", bus4.instr_count); end
    n_cmp++;
    if (bus.instr_count !== 16'd20) begin n_bad++; $display("FAIL sat_cnt16: got %0d want 20", bus.instr_count); end
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; step = 1'b0;
    for (int i = 0; i < 32; i++) rom[i] = 32'h0;
    test_reset();
    test_program();
    test_rtype_sweep();
    test_single_step();
    test_illegal();
    test_reset_mid();
    test_random();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
